// File: rtl/contador_bcd_n_if.sv
// Bus bundle for the N-digit BCD counter: control inputs, load data and
// the registered outputs. The master side drives control, the slave side
// (the counter) drives sal/tc/err.
//
// Handshake: there is no valid/ready pair on this bus. Every posedge of
// clk samples load/clk_en/up/din. The registered outputs sal/tc/err are
// valid on every cycle after reset has been applied.
interface contador_bcd_n_if #(
  parameter int DIGITS = 3
);
  logic                  clk_en;
  logic                  up;
  logic                  load;
  logic [4*DIGITS-1:0]   din;
  logic [4*DIGITS-1:0]   sal;
  logic                  tc;
  logic                  err;

  modport master (
    output clk_en, up, load, din,
    input  sal, tc, err
  );

  modport slave (
    input  clk_en, up, load, din,
    output sal, tc, err
  );
endinterface

// File: rtl/contador_bcd_n.sv
// Parametrised N-digit packed-BCD up/down counter with validated parallel
// load, terminal-count pulse, sticky invalid-load flag and wrap/saturate
// behaviour at the limits. The carry/borrow chain is evaluated across all
// digits in a single cycle.
module contador_bcd_n #(
  parameter int DIGITS = 3,
  parameter bit WRAP   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  contador_bcd_n_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0] sal_q;
  logic         tc_q;
  logic         err_q;

  logic [W-1:0] step_val;
  logic         at_limit;
  logic         din_ok;
  logic         chain;
  logic [3:0]   digit;

  assign bus.sal = sal_q;
  assign bus.tc  = tc_q;
  assign bus.err = err_q;

  // Next count value, terminal detection and load-data validation.
  // 'chain' carries the increment (or borrow) into the next digit; it is
  // still set after the last digit only when every digit was 9 (up) or 0
  // (down), which is exactly the terminal condition.
  always_comb begin
    step_val = sal_q;
    chain    = 1'b1;
    din_ok   = 1'b1;
    digit    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = sal_q[4*i +: 4];
      if (chain) begin
        if (bus.up) begin
          if (digit == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digit + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = digit - 4'd1;
            chain = 1'b0;
          end
        end
      end
      if (bus.din[4*i +: 4] > 4'd9) begin
        din_ok = 1'b0;
      end
    end
    at_limit = chain;
  end

  // State update: reset beats load, load beats counting, otherwise hold.
  // In saturate mode the value is frozen at the limit while tc still pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sal_q <= '0;
      tc_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (bus.load) begin
      tc_q <= 1'b0;
      if (din_ok) begin
        sal_q <= bus.din;
      end else begin
        err_q <= 1'b1;
      end
    end else if (bus.clk_en) begin
      tc_q <= at_limit;
      if (!(at_limit && !WRAP)) begin
        sal_q <= step_val;
      end
    end else begin
      tc_q <= 1'b0;
    end
  end
endmodule
